// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end for the Mini MIPS core.
// It owns the fetch PC and issues word-addressed reads to instruction memory
// through a valid/ready handshake. In-order responses go into a small buffer
// that decode drains as {pc, instruction}.
// A redirect loads a new fetch PC and throws away everything already fetched.
// It also throws away every response still in flight.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [CNT_W-1:0]   r_outstanding;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic [DATA_W-1:0]  r_buf_data [DEPTH];
    logic [ADDR_W-1:0]  r_buf_pc   [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic               w_pop;
    logic [SUM_W-1:0]   w_used;
    logic               w_accept;
    logic               w_rsp;
    logic               w_rsp_drop;
    logic               w_push;
    logic               w_drop_dec;
    logic [CNT_W-1:0]   w_out_next;
    logic [CNT_W-1:0]   w_drop_next;
    logic [ADDR_W-1:0]  w_rsp_pc;

    assign inst_valid    = (r_count != '0);
    assign inst_data     = r_buf_data[r_head];
    assign inst_pc       = r_buf_pc[r_head];
    assign imem_req_addr = r_fetch_pc;

    assign w_pop = inst_valid && inst_ready;

    // An entry popped this cycle frees its slot at once.
    // This lets a 1-cycle memory stream without bubbles at DEPTH=2.
    assign w_used = SUM_W'(r_outstanding) + SUM_W'(r_count) - SUM_W'(w_pop);

    assign imem_req_valid = (r_state == ST_RUN) && !redirect && (w_used < SUM_W'(DEPTH));
    assign w_accept       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is spurious and is ignored.
    assign w_rsp      = imem_rsp_valid && (r_outstanding != '0);
    assign w_rsp_drop = w_rsp && (redirect || (r_drop_cnt != '0));
    assign w_push     = w_rsp && !w_rsp_drop;
    assign w_drop_dec = w_rsp && (r_drop_cnt != '0);

    assign w_out_next  = r_outstanding + CNT_W'(w_accept) - CNT_W'(w_rsp);
    assign w_drop_next = redirect ? w_out_next : (r_drop_cnt - CNT_W'(w_drop_dec));

    // A push only happens when nothing is waiting to be dropped.
    // At that point every outstanding request belongs to the current stream,
    // and those requests sit at consecutive addresses ending just below fetch PC.
    // So the PC of the oldest one can be computed instead of stored per request.
    assign w_rsp_pc = r_fetch_pc - ADDR_W'(r_outstanding);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: flush while stale responses are still owed
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_BOOT: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (redirect && (w_drop_next != '0)) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_drop_next == '0) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    // Fetch PC, in-flight request count and drop count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_out_next;
            r_drop_cnt    <= w_drop_next;
            if (redirect) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
            end
        end
    end

    // Instruction buffer: circular FIFO of {pc, data}, emptied on redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_buf_data[i] <= '0;
                r_buf_pc[i]   <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_buf_data[r_tail] <= imem_rsp_data;
                r_buf_pc[r_tail]   <= w_rsp_pc;
            end
            if (redirect) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_pop) begin
                    r_head <= r_head + PTR_W'(1);
                end
                if (w_push) begin
                    r_tail <= r_tail + PTR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// An in-order instruction memory model with configurable latency serves requests.
// A stream-level reference checks the results: after reset or a redirect, decode
// must see PC = start, start+1, ... and data = mem(PC), with nothing stale or lost.
module tb_instr_fetch_unit;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid = 1'b0;
    logic [DW-1:0] imem_rsp_data = '0;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_pc;

    instr_fetch_unit #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .RESET_PC(RPC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // memory model: accepted addresses and the cycle each response is due
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          last_due;
    int          cyc;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          spurious_en = 1'b0;

    // stream reference
    logic [31:0] m_req_pc;
    logic [31:0] m_exp_pc;
    bit          m_empty_next;
    bit          prev_pend;
    logic [31:0] prev_addr;
    logic [31:0] popped_pc[$];
    int          n_acc;

    // values sampled in the most recent step
    bit          s_rv;
    logic [31:0] s_ra;
    bit          s_iv;
    logic [31:0] s_ipc;

    task automatic model_reset();
        mq_addr.delete();
        mq_due.delete();
        popped_pc.delete();
        last_due     = 0;
        cyc          = 0;
        m_req_pc     = RPC;
        m_exp_pc     = RPC;
        m_empty_next = 1'b0;
        prev_pend    = 1'b0;
        prev_addr    = '0;
        n_acc        = 0;
    endtask

    task automatic step(input bit rd, input logic [31:0] rpc, input bit irdy, input bit mrdy);
        bit rsp;
        bit acc;
        bit pop;
        int due;
        @(negedge clk);
        redirect       = rd;
        redirect_pc    = rpc;
        inst_ready     = irdy;
        imem_req_ready = mrdy;
        rsp = (mq_addr.size() > 0) && (mq_due[0] <= cyc);
        if (rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(mq_addr[0]);
        end else if (spurious_en && (mq_addr.size() == 0) && ($urandom_range(0, 9) == 0)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        s_rv  = imem_req_valid;
        s_ra  = imem_req_addr;
        s_iv  = inst_valid;
        s_ipc = inst_pc;
        acc = imem_req_valid && mrdy;
        pop = inst_valid && irdy;
        if (m_empty_next) chk("empty_after_redirect", inst_valid, 1'b0);
        if (rd) chk("no_req_in_redirect", imem_req_valid, 1'b0);
        if (imem_req_valid) chk("req_addr", imem_req_addr, m_req_pc);
        if (prev_pend && !rd) begin
            chk("req_hold_valid", imem_req_valid, 1'b1);
            chk("req_hold_addr", imem_req_addr, prev_addr);
        end
        if (pop) begin
            chk("inst_pc", inst_pc, m_exp_pc);
            chk("inst_data", inst_data, memfn(m_exp_pc));
            popped_pc.push_back(inst_pc);
            m_exp_pc = m_exp_pc + 32'd1;
        end
        if (rsp) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (acc) begin
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(due);
            last_due = due;
            m_req_pc = m_req_pc + 32'd1;
            n_acc++;
            chk("inflight_bound", (mq_addr.size() <= DEPTH), 1'b1);
        end
        prev_pend = imem_req_valid && !acc;
        prev_addr = imem_req_addr;
        if (rd) begin
            m_req_pc = rpc;
            m_exp_pc = rpc;
        end
        m_empty_next = rd;
        cyc++;
        @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, imem_req_valid, 1'b0);
        chk({tag, "_req_addr"}, imem_req_addr, RPC);
        chk({tag, "_inst_valid"}, inst_valid, 1'b0);
        chk({tag, "_inst_data"}, inst_data, 32'h0);
        chk({tag, "_inst_pc"}, inst_pc, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        redirect       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    int base;

    initial begin
        // 1: zero-bubble sequential fetch with a 1-cycle memory
        lat_min = 1; lat_max = 1; spurious_en = 1'b0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            step(1'b0, '0, 1'b1, 1'b1);
            if (c == 0) begin
                chk("t1_boot_req_valid", s_rv, 1'b0);
            end else begin
                chk("t1_req_valid", s_rv, 1'b1);
                chk("t1_req_addr", s_ra, 32'(c - 1));
            end
            if (c >= 3) begin
                chk("t1_inst_valid", s_iv, 1'b1);
                chk("t1_inst_pc", s_ipc, 32'(c - 3));
            end else begin
                chk("t1_inst_valid_early", s_iv, 1'b0);
            end
        end

        // 2: decode stalled -> only DEPTH requests accepted until a pop
        do_reset();
        for (int c = 0; c < 10; c++) step(1'b0, '0, 1'b0, 1'b1);
        chk("t2_accepts", n_acc, DEPTH);
        chk("t2_req_blocked", s_rv, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("t2_req_on_pop", s_rv, 1'b1);
        for (int c = 0; c < 4; c++) step(1'b0, '0, 1'b1, 1'b1);
        chk("t2_pop_count", (popped_pc.size() >= 3), 1'b1);
        chk("t2_order", popped_pc[1], 32'h1);

        // 3: redirect with two requests in flight on a 3-cycle memory
        lat_min = 3; lat_max = 3;
        do_reset();
        for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b1, 1'b1);
        chk("t3_inflight", mq_addr.size(), 2);
        lat_min = 1; lat_max = 1;
        step(1'b1, 32'h40, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("t3_flush1_req", s_rv, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("t3_flush2_req", s_rv, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("t3_run_req", s_rv, 1'b1);
        chk("t3_run_addr", s_ra, 32'h40);
        for (int c = 0; c < 5; c++) step(1'b0, '0, 1'b1, 1'b1);
        chk("t3_first_pc", popped_pc[0], 32'h40);
        chk("t3_second_pc", popped_pc[1], 32'h41);

        // 4: redirect in the same cycle as a response arrives
        do_reset();
        for (int c = 0; c < 6; c++) step(1'b0, '0, 1'b1, 1'b1);
        chk("t4_rsp_due", ((mq_addr.size() == 1) && (mq_due[0] == cyc)), 1'b1);
        step(1'b1, 32'h100, 1'b1, 1'b1);
        base = popped_pc.size();
        step(1'b0, '0, 1'b1, 1'b1);
        chk("t4_empty", s_iv, 1'b0);
        chk("t4_req_valid", s_rv, 1'b1);
        chk("t4_req_addr", s_ra, 32'h100);
        for (int c = 0; c < 5; c++) step(1'b0, '0, 1'b1, 1'b1);
        chk("t4_next_pc", popped_pc[base], 32'h100);

        // 5: fetch PC wraps from all-ones to zero
        step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        base = popped_pc.size();
        for (int c = 0; c < 8; c++) step(1'b0, '0, 1'b1, 1'b1);
        chk("t5_pc_max", popped_pc[base], 32'hFFFF_FFFF);
        chk("t5_pc_wrap", popped_pc[base + 1], 32'h0);

        // 6: asynchronous reset mid-stream with a request pending and rsp_valid high
        @(negedge clk);
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        #1;
        chk("t6_req_pending", imem_req_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        @(posedge clk);
        #1;
        chk("t6_rsp_ignored", inst_valid, 1'b0);
        imem_rsp_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        step(1'b0, '0, 1'b1, 1'b1);
        chk("t6_boot_req", s_rv, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("t6_restart_valid", s_rv, 1'b1);
        chk("t6_restart_addr", s_ra, RPC);

        // random traffic: variable latency, stalls, redirects, spurious responses
        lat_min = 1; lat_max = 3; spurious_en = 1'b1;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit          rd;
            logic [31:0] rpc;
            rd  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom;
            step(rd, rpc, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
        end
        chk("rand_progress", (popped_pc.size() > 200), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
